// File: rtl/axis_packet_serializer_if.sv
// Bundle of the parallel packet input port and the AXIS beat output port of the serializer.
// "master" is the serializer's own view; "slave" is the view of whatever drives and sinks it.
interface axis_packet_serializer_if #(
    parameter int WORD_W  = 8,
    parameter int BUS_W   = 8,
    parameter int N_BEATS = 10
);
    localparam int WORDS_PER_BEAT = BUS_W / WORD_W;

    logic                                      s_valid;
    logic                                      s_ready;
    logic [N_BEATS*WORDS_PER_BEAT*WORD_W-1:0]  s_data;
    logic                                      m_valid;
    logic                                      m_ready;
    logic [WORDS_PER_BEAT*WORD_W-1:0]          m_data;
    logic                                      m_last;

    modport master (
        input  s_valid, s_data, m_ready,
        output s_ready, m_valid, m_data, m_last
    );

    modport slave (
        output s_valid, s_data, m_ready,
        input  s_ready, m_valid, m_data, m_last
    );
endinterface

// File: rtl/axis_packet_serializer.sv
// Takes a whole N_BEATS packet in one handshake and replays it as an AXIS stream,
// one beat per cycle, reloading on the last beat so back-to-back packets have no bubble.
//
// state | meaning
// IDLE  | no packet held; s_ready=1, m_valid=0
// SEND  | streaming pkt_q[cnt_q]; m_last on beat N_BEATS-1
module axis_packet_serializer #(
    parameter int WORD_W  = 8,
    parameter int BUS_W   = 8,
    parameter int N_BEATS = 10
) (
    input  logic                    clk,
    input  logic                    rst,
    axis_packet_serializer_if.master bus
);
    localparam int WORDS_PER_BEAT = BUS_W / WORD_W;
    localparam int BEAT_W         = WORDS_PER_BEAT * WORD_W;
    localparam int CNT_W          = (N_BEATS > 1) ? $clog2(N_BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_BEATS - 1);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t                          state_q, state_d;
    logic [CNT_W-1:0]                cnt_q, cnt_d;
    logic [N_BEATS-1:0][BEAT_W-1:0]  pkt_q;
    logic [BEAT_W-1:0]               data_q, data_d;
    logic                            load;
    logic                            valid_c;
    logic                            last_c;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            pkt_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            if (load) begin
                pkt_q <= bus.s_data;
            end
        end
    end

    // m_data is registered so it holds the last sent beat while idle
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        load    = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.s_valid) begin
                    load    = 1'b1;
                    cnt_d   = '0;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (bus.m_ready) begin
                    if (cnt_q == LAST_CNT) begin
                        cnt_d = '0;
                        if (bus.s_valid) begin
                            load = 1'b1;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        cnt_d  = CNT_W'(cnt_q + 1'b1);
                        data_d = pkt_q[cnt_d];
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (load) begin
            data_d = bus.s_data[BEAT_W-1:0];
        end
    end

    always_comb begin
        valid_c     = (state_q == SEND);
        last_c      = valid_c && (cnt_q == LAST_CNT);
        bus.m_valid = valid_c;
        bus.m_last  = last_c;
        bus.m_data  = data_q;
        bus.s_ready = (state_q == IDLE) || (valid_c && bus.m_ready && last_c);
    end
endmodule

// File: tb/tb_axis_packet_serializer.sv
// Directed bench for the packet serializer: a 4-beat/16-bit instance checked through an
// expected-beat queue, plus a 1-beat/8-bit instance for the single-beat packet case.
module tb_axis_packet_serializer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    axis_packet_serializer_if #(.WORD_W(8), .BUS_W(16), .N_BEATS(4)) bus ();
    axis_packet_serializer_if #(.WORD_W(8), .BUS_W(8),  .N_BEATS(1)) bus1 ();

    axis_packet_serializer #(.WORD_W(8), .BUS_W(16), .N_BEATS(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    axis_packet_serializer #(.WORD_W(8), .BUS_W(8), .N_BEATS(1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1.master)
    );

    int          n_vec = 0;
    int          n_err = 0;
    logic [16:0] exp_q[$];
    bit          bp_en = 1'b0;
    logic        prv_v, prv_r, prv_last;
    logic [15:0] prv_data;
    logic [16:0] e;
    logic [63:0] p;
    logic [7:0]  pk[5];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_pkt(input logic [63:0] pkt);
        for (int b = 0; b < 4; b++) begin
            exp_q.push_back({(b == 3) ? 1'b1 : 1'b0, pkt[b*16 +: 16]});
        end
    endtask

    // Called just after a rising edge; returns just after the edge that took the packet.
    task automatic offer(input logic [63:0] pkt, input bit hold);
        bit done;
        done = 1'b0;
        bus.s_valid = 1'b1;
        bus.s_data  = pkt;
        for (int t = 0; t < 500 && !done; t++) begin
            @(negedge clk);
            if (bus.s_ready === 1'b1) begin
                push_pkt(pkt);
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        if (!hold) bus.s_valid = 1'b0;
        check("offer_accepted", done, 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_m_valid"}, bus.m_valid, 0);
        check({tag, "_m_last"},  bus.m_last,  0);
        check({tag, "_s_ready"}, bus.s_ready, 1);
        check({tag, "_m_data"},  bus.m_data,  0);
    endtask

    initial begin
        bus.s_valid  = 1'b0;
        bus.s_data   = '0;
        bus.m_ready  = 1'b0;
        bus1.s_valid = 1'b0;
        bus1.s_data  = '0;
        bus1.m_ready = 1'b1;
        prv_v = 1'b0; prv_r = 1'b0; prv_last = 1'b0; prv_data = '0;

        fork
            begin : monitor
                forever begin
                    @(negedge clk);
                    if (rst) begin
                        prv_v = 1'b0;
                    end else begin
                        if (prv_v && !prv_r) begin
                            check("stable_m_valid", bus.m_valid, 1);
                            check("stable_m_data",  bus.m_data,  prv_data);
                            check("stable_m_last",  bus.m_last,  prv_last);
                        end
                        if (bus.m_valid && bus.m_ready) begin
                            if (exp_q.size() == 0) begin
                                check("sb_unexpected_beat", 64'(exp_q.size()), 1);
                            end else begin
                                e = exp_q.pop_front();
                                check("sb_beat_data", bus.m_data, e[15:0]);
                                check("sb_beat_last", bus.m_last, e[16]);
                            end
                        end
                        prv_v    = bus.m_valid;
                        prv_r    = bus.m_ready;
                        prv_data = bus.m_data;
                        prv_last = bus.m_last;
                    end
                end
            end
            begin : ready_gen
                forever begin
                    @(posedge clk);
                    #1;
                    if (bp_en) bus.m_ready = ($urandom_range(99) < 20);
                end
            end
            begin : watchdog
                #1000000;
                $display("FAIL watchdog: simulation did not complete in time");
                $fatal(1);
            end
        join_none

        // reset held with random inputs, then released with s_valid low
        for (int i = 0; i < 4; i++) begin
            bus.s_valid = 1'($urandom_range(1));
            bus.s_data  = {$urandom, $urandom};
            bus.m_ready = 1'($urandom_range(1));
            @(negedge clk);
            check_reset_outputs("rst_held");
            check("rst_held_s_ready_n1", bus1.s_ready, 1);
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        bus.s_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.s_data  = {$urandom, $urandom};
            bus.m_ready = 1'($urandom_range(1));
            @(negedge clk);
            check_reset_outputs("post_rst");
            @(posedge clk);
            #1;
        end

        // single packet, words 0x00..0x07
        bus.m_ready = 1'b1;
        bus.s_valid = 1'b1;
        bus.s_data  = 64'h0706_0504_0302_0100;
        @(negedge clk);
        check("single_accept_ready", bus.s_ready, 1);
        push_pkt(bus.s_data);
        @(posedge clk);
        #1;
        bus.s_valid = 1'b0;
        bus.s_data  = {$urandom, $urandom};
        for (int b = 0; b < 4; b++) begin
            @(negedge clk);
            check("single_m_valid", bus.m_valid, 1);
            check("single_m_data",  bus.m_data,  16'h0100 + 16'(b) * 16'h0202);
            check("single_m_last",  bus.m_last,  (b == 3));
            check("single_s_ready", bus.s_ready, (b == 3));
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        check("single_idle_m_valid", bus.m_valid, 0);
        check("single_idle_m_data_hold", bus.m_data, 16'h0706);
        @(posedge clk);
        #1;

        // back-to-back packets A and B with s_valid held
        bus.s_valid = 1'b1;
        bus.s_data  = 64'h1716_1514_1312_1110;
        @(negedge clk);
        check("b2b_accept_a", bus.s_ready, 1);
        push_pkt(bus.s_data);
        @(posedge clk);
        #1;
        bus.s_data = 64'h2726_2524_2322_2120;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("b2b_m_valid", bus.m_valid, 1);
            check("b2b_s_ready", bus.s_ready, (i == 3 || i == 7));
            if (i == 3) push_pkt(bus.s_data);
            @(posedge clk);
            #1;
            if (i == 3) bus.s_valid = 1'b0;
        end
        @(negedge clk);
        check("b2b_idle_m_valid", bus.m_valid, 0);
        @(posedge clk);
        #1;

        // 50 random packets under 20% downstream readiness
        bp_en = 1'b1;
        for (int k = 0; k < 50; k++) begin
            p = {$urandom, $urandom};
            if ($urandom_range(1) == 1 && k < 49) begin
                offer(p, 1'b1);
            end else begin
                offer(p, 1'b0);
                for (int g = 0; g < int'($urandom_range(2)); g++) begin
                    bus.s_data = {$urandom, $urandom};
                    @(posedge clk);
                    #1;
                end
            end
        end
        for (int t = 0; t < 5000 && exp_q.size() != 0; t++) begin
            @(posedge clk);
            #1;
        end
        check("bp_drained", 64'(exp_q.size()), 0);
        bp_en = 1'b0;
        bus.m_ready = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("bp_idle_m_valid", bus.m_valid, 0);
        @(posedge clk);
        #1;

        // reset after the beat 1 handshake, then a fresh packet from beat 0
        offer(64'h3736_3534_3332_3130, 1'b0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b1;
        exp_q.delete();
        #1;
        check("rst_mid_m_valid", bus.m_valid, 0);
        check("rst_mid_s_ready", bus.s_ready, 1);
        check("rst_mid_m_last",  bus.m_last,  0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_mid_after_m_valid", bus.m_valid, 0);
        @(posedge clk);
        #1;
        offer(64'h4746_4544_4342_4140, 1'b0);
        @(negedge clk);
        check("rst_restart_m_valid", bus.m_valid, 1);
        check("rst_restart_m_data",  bus.m_data,  16'h4140);
        @(posedge clk);
        #1;
        for (int t = 0; t < 20 && exp_q.size() != 0; t++) begin
            @(posedge clk);
            #1;
        end
        check("rst_restart_drained", 64'(exp_q.size()), 0);

        // single-beat packets on the N_BEATS=1 instance
        pk = '{8'hA5, 8'h3C, 8'hFF, 8'h00, 8'h81};
        bus1.s_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (i < 5) bus1.s_data = pk[i];
            else begin
                bus1.s_valid = 1'b0;
                bus1.s_data  = 8'h5A;
            end
            @(negedge clk);
            check("n1_s_ready", bus1.s_ready, 1);
            if (i > 0) begin
                check("n1_m_valid", bus1.m_valid, 1);
                check("n1_m_data",  bus1.m_data,  pk[i-1]);
                check("n1_m_last",  bus1.m_last,  1);
            end else begin
                check("n1_first_m_valid", bus1.m_valid, 0);
            end
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        check("n1_idle_m_valid", bus1.m_valid, 0);
        check("n1_idle_m_data_hold", bus1.m_data, 8'h81);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
